// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LOAD,
    DONE,
    ERROR
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_WIDTH     = 8;
  localparam int WORD_WIDTH     = BYTES_PER_WORD * BYTE_WIDTH;

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// Collects bytes LSB-first into a word. The completed word and its strobe are
// presented combinationally on the edge that accepts the last byte, so the
// parent can register the write in the very next cycle.
module byte_assembler
  import loader_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [BYTE_WIDTH-1:0] in_data,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_valid
);

  localparam int COUNT_WIDTH = $clog2(BYTES_PER_WORD);

  logic [COUNT_WIDTH-1:0] byte_count;
  logic [WORD_WIDTH-1:0]  shift_reg;

  // New bytes enter at the top, so after four shifts byte 0 sits in [7:0].
  assign word       = {in_data, shift_reg[WORD_WIDTH-1:BYTE_WIDTH]};
  assign word_valid = accept && (byte_count == COUNT_WIDTH'(BYTES_PER_WORD - 1));

  // Byte counter and shift-in register; the partial word survives input gaps.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset || clear) begin
      byte_count <= '0;
      shift_reg  <= '0;
    end else if (accept) begin
      byte_count <= byte_count + COUNT_WIDTH'(1);
      shift_reg  <= word;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory,
// one write per word, holding the CPU in reset until the image is complete.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH   = WORD_WIDTH,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_DEPTH    = 256,
  parameter int BASE_ADDRESS = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [BYTE_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  load_error
);

  localparam int                     COUNT_WIDTH = $clog2(MEM_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0]  BASE        = ADDR_WIDTH'(BASE_ADDRESS);
  localparam logic [WORD_WIDTH-1:0]  DEPTH_LIMIT = WORD_WIDTH'(MEM_DEPTH);

  loader_state_t          state;
  logic [COUNT_WIDTH-1:0] words_left;
  logic                   accept;
  logic                   start_load;
  logic [WORD_WIDTH-1:0]  word;
  logic                   word_valid;

  assign accept     = in_valid && in_ready;
  assign start_load = start && (state == IDLE || state == DONE || state == ERROR);

  // One assembler serves both the header word and the instruction words.
  byte_assembler u_assembler (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_load),
    .accept     (accept),
    .in_data    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Load FSM with registered handshake, write strobe and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      words_left    <= '0;
      in_ready      <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= BASE;
      write_data    <= '0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      load_error    <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      if (write_enable) write_address <= write_address + ADDR_WIDTH'(1);

      case (state)
        IDLE, DONE, ERROR: begin
          if (start_load) begin
            state         <= HEADER;
            in_ready      <= 1'b1;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            load_error    <= 1'b0;
            write_address <= BASE;
          end
        end

        HEADER: begin
          if (word_valid) begin
            if (word == '0) begin
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else if (word > DEPTH_LIMIT) begin
              state      <= ERROR;
              in_ready   <= 1'b0;
              load_error <= 1'b1;
            end else begin
              state      <= LOAD;
              words_left <= word[COUNT_WIDTH-1:0];
            end
          end
        end

        LOAD: begin
          if (word_valid) begin
            write_enable <= 1'b1;
            write_data   <= DATA_WIDTH'(word);
            words_left   <= words_left - COUNT_WIDTH'(1);
            if (words_left == COUNT_WIDTH'(1)) begin
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
